// File: rtl/stimulus_sequencer_pkg.sv
// Shared types and default parameters for the stimulus sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int DEF_PAT_W      = 16;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_RST_CYCLES = 2;

    // Length field must hold PAT_W itself, hence one bit more than the index.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/stimulus_sequencer_if.sv
// Host-side configuration/control/status bundle of the stimulus sequencer.
interface stimulus_sequencer_if
    import seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) ();
    localparam int LEN_W = len_w(PAT_W);

    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_repeat;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] b_count;
    logic [CNT_W-1:0] c_count;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_repeat, start,
        input  busy, done, b_count, c_count
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_repeat, start,
        output busy, done, b_count, c_count
    );

endinterface

// File: rtl/stimulus_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the b/c hit counts.
module sat_counter
    import seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!nReset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stimulus_sequencer.sv
// Sequences a serial datapath: reset window, then plays a programmed pattern
// for a programmed number of passes while counting b/c hits.
module stimulus_sequencer
    import seq_pkg::*;
#(
    parameter int PAT_W      = DEF_PAT_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                 clock,
    input  logic                 nReset,
    stimulus_sequencer_if.slave  host,
    output logic                 dut_a,
    output logic                 dut_nReset,
    input  logic                 dut_b,
    input  logic                 dut_c
);

    localparam int LEN_W = len_w(PAT_W);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] repeat_q, repeat_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] pass_left_q, pass_left_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic             dut_a_q, dut_a_d;
    logic             dut_nreset_q, dut_nreset_d;
    logic             clear_cnt;
    logic [PAT_W-1:0] pat_shift;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        repeat_d    = repeat_q;
        bit_idx_d   = bit_idx_q;
        pass_left_d = pass_left_q;
        rst_cnt_d   = rst_cnt_q;
        clear_cnt   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A config write wins over a simultaneous start.
                if (host.cfg_we) begin
                    pattern_d = host.cfg_pattern;
                    repeat_d  = host.cfg_repeat;
                    if ((host.cfg_len == '0) || (host.cfg_len > LEN_W'(PAT_W))) begin
                        len_d = LEN_W'(PAT_W);
                    end else begin
                        len_d = host.cfg_len;
                    end
                end else if (host.start) begin
                    clear_cnt = 1'b1;
                    if (repeat_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = RESET;
                        bit_idx_d   = '0;
                        pass_left_d = repeat_q;
                        rst_cnt_d   = RC_W'(RST_CYCLES - 1);
                    end
                end
            end
            RESET: begin
                if (rst_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            RUN: begin
                if (bit_idx_q == (len_q - LEN_W'(1))) begin
                    if (pass_left_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        bit_idx_d   = '0;
                        pass_left_d = pass_left_q - CNT_W'(1);
                    end
                end else begin
                    bit_idx_d = bit_idx_q + LEN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Drives are registered, so they follow the next state and bit index.
        pat_shift    = pattern_q >> bit_idx_d;
        dut_a_d      = (state_d == RUN) & pat_shift[0];
        dut_nreset_d = (state_d != RESET);
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q      <= IDLE;
            pattern_q    <= '0;
            len_q        <= LEN_W'(1);
            repeat_q     <= CNT_W'(1);
            bit_idx_q    <= '0;
            pass_left_q  <= '0;
            rst_cnt_q    <= '0;
            dut_a_q      <= 1'b0;
            dut_nreset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            repeat_q     <= repeat_d;
            bit_idx_q    <= bit_idx_d;
            pass_left_q  <= pass_left_d;
            rst_cnt_q    <= rst_cnt_d;
            dut_a_q      <= dut_a_d;
            dut_nreset_q <= dut_nreset_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_b_cnt (
        .clock  (clock),
        .nReset (nReset),
        .clear  (clear_cnt),
        .inc    ((state_q == RUN) & dut_b),
        .count  (host.b_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_c_cnt (
        .clock  (clock),
        .nReset (nReset),
        .clear  (clear_cnt),
        .inc    ((state_q == RUN) & dut_c),
        .count  (host.c_count)
    );

    assign host.busy  = (state_q == RESET) || (state_q == RUN);
    assign host.done  = (state_q == DONE);
    assign dut_a      = dut_a_q;
    assign dut_nReset = dut_nreset_q;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Scoreboard bench for stimulus_sequencer: a stimulus thread predicts each
// sequence from a behavioural model, a negedge monitor checks what the DUT shows.
module tb_stimulus_sequencer;
    import seq_pkg::*;

    localparam int PAT_W = 16;
    localparam int CNT_W = 8;
    localparam int RSTC  = 2;
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clock  = 1'b0;
    logic nReset = 1'b0;
    logic dut_a, dut_nReset, dut_b;
    logic dut_c  = 1'b0;

    stimulus_sequencer_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) host ();

    stimulus_sequencer #(.PAT_W(PAT_W), .CNT_W(CNT_W), .RST_CYCLES(RSTC)) u_dut (
        .clock      (clock),
        .nReset     (nReset),
        .host       (host),
        .dut_a      (dut_a),
        .dut_nReset (dut_nReset),
        .dut_b      (dut_b),
        .dut_c      (dut_c)
    );

    assign dut_b = dut_a;
    always #5 clock = ~clock;

    typedef struct {
        int exp_cyc;
        int exp_rst;
        int exp_b;
        int exp_c;
    } exp_t;

    exp_t       sb[$];
    bit         bit_q[$];
    bit         c_plan[int];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    int         rst_seen = 0;
    logic [PAT_W-1:0] m_pat = '0;
    int         m_len = 1;
    int         m_rep = 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        dut_c = c_plan.exists(cyc) ? c_plan[cyc] : 1'b0;
    end

    always @(negedge clock) begin
        if (mon_en) begin
            if (host.busy === 1'b1 && dut_nReset === 1'b1) begin
                n_checks++;
                if (bit_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL run_bit: unexpected playback cycle, dut_a=%0b (cycle %0d)", dut_a, cyc);
                end else begin
                    n_checks--;
                    check("dut_a_run", dut_a, bit_q.pop_front());
                end
            end
            if (host.busy === 1'b1 && dut_nReset === 1'b0) begin
                rst_seen++;
                check("dut_a_in_reset", dut_a, 0);
            end
            if (host.busy !== 1'b1) begin
                check("idle_nReset", dut_nReset, 1);
                check("idle_a", dut_a, 0);
            end
            if (host.done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL done: unexpected done pulse (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    n_checks--;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.exp_cyc);
                    check("reset_window", rst_seen, e.exp_rst);
                    check("b_count", host.b_count, e.exp_b);
                    check("c_count", host.c_count, e.exp_c);
                    check("bits_left", bit_q.size(), 0);
                end
            end
            if (host.busy !== 1'b1 && host.done !== 1'b1) rst_seen = 0;
        end
    end

    task automatic write_cfg(input logic [PAT_W-1:0] p, input int l, input int r);
        host.cfg_we      = 1'b1;
        host.cfg_pattern = p;
        host.cfg_len     = LEN_W'(l);
        host.cfg_repeat  = CNT_W'(r);
        @(posedge clock); #1;
        host.cfg_we = 1'b0;
        m_pat = p;
        m_len = (l == 0 || l > PAT_W) ? PAT_W : l;
        m_rep = r;
    endtask

    // c_mode: 0 all zero, 1 all one, 2 random
    task automatic launch(input int c_mode, input bit expect_done);
        int   e0, lr, bsum, csum;
        exp_t e;
        e0 = cyc + 1;
        lr = m_len * m_rep;
        for (int n = e0; n <= e0 + RSTC + lr + 2; n++)
            c_plan[n] = (c_mode == 0) ? 1'b0 : (c_mode == 1) ? 1'b1 : 1'($urandom);
        csum = 0;
        bsum = 0;
        if (m_rep != 0) begin
            for (int n = e0 + RSTC; n < e0 + RSTC + lr; n++) csum += c_plan[n];
            for (int i = 0; i < m_len; i++) bsum += m_pat[i];
            bsum = bsum * m_rep;
        end
        for (int p = 0; p < m_rep; p++)
            for (int i = 0; i < m_len; i++) bit_q.push_back(m_pat[i]);
        if (expect_done) begin
            e.exp_cyc = (m_rep == 0) ? e0 : e0 + RSTC + lr;
            e.exp_rst = (m_rep == 0) ? 0 : RSTC;
            e.exp_b   = sat(bsum);
            e.exp_c   = sat(csum);
            sb.push_back(e);
        end
        host.start = 1'b1;
        @(posedge clock); #1;
        host.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d sequences still pending", sb.size());
            sb.delete();
            bit_q.delete();
        end
    endtask

    initial begin
        host.cfg_we      = 1'b0;
        host.cfg_pattern = '0;
        host.cfg_len     = '0;
        host.cfg_repeat  = '0;
        host.start       = 1'b1;
        nReset           = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", host.busy, 0);
        check("rst_done", host.done, 0);
        check("rst_dut_a", dut_a, 0);
        check("rst_dut_nReset", dut_nReset, 1);
        check("rst_b_count", host.b_count, 0);
        check("rst_c_count", host.c_count, 0);
        host.start = 1'b0;
        nReset     = 1'b1;
        mon_en     = 1'b1;

        write_cfg(16'b1011, 4, 2);
        launch(0, 1);
        wait_done();

        write_cfg(16'h00ff, 5, 0);
        launch(1, 1);
        wait_done();

        // start/cfg_we while busy must not disturb the running sequence
        write_cfg(16'h5a3c, 12, 3);
        launch(2, 1);
        repeat (RSTC + 4) @(posedge clock);
        #1;
        host.cfg_we      = 1'b1;
        host.cfg_pattern = '0;
        host.start       = 1'b1;
        @(posedge clock); #1;
        host.cfg_we = 1'b0;
        host.start  = 1'b0;
        wait_done();
        launch(2, 1);
        wait_done();

        // cfg_we and start together in IDLE: write only
        host.cfg_we      = 1'b1;
        host.cfg_pattern = 16'h0003;
        host.cfg_len     = LEN_W'(2);
        host.cfg_repeat  = CNT_W'(1);
        host.start       = 1'b1;
        @(posedge clock); #1;
        host.cfg_we = 1'b0;
        host.start  = 1'b0;
        m_pat = 16'h0003; m_len = 2; m_rep = 1;
        repeat (3) @(posedge clock);
        #1;
        check("we_start_no_busy", host.busy, 0);
        launch(0, 1);
        wait_done();

        // abort in RUN
        write_cfg(16'hf0f0, 16, 2);
        launch(2, 0);
        repeat (RSTC + 5) @(posedge clock);
        #1;
        nReset = 1'b0;
        @(posedge clock); #1;
        nReset = 1'b1;
        bit_q.delete();
        check("abort_busy", host.busy, 0);
        check("abort_done", host.done, 0);
        check("abort_b_count", host.b_count, 0);
        check("abort_c_count", host.c_count, 0);
        m_pat = '0; m_len = 1; m_rep = 1;
        launch(1, 1);
        wait_done();
        write_cfg(16'h0001, 3, 2);
        launch(2, 1);
        wait_done();

        for (int k = 0; k < 8; k++) begin
            write_cfg(PAT_W'($urandom), int'($urandom_range(0, PAT_W)), int'($urandom_range(0, 4)));
            launch(2, 1);
            wait_done();
        end

        write_cfg('1, 16, 20);
        launch(1, 1);
        wait_done();

        repeat (3) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
